// File: rtl/serial_mem_slave.sv
// serial_mem_slave
// Serial-bus memory slave. A configuration frame arrives MSB first on
// `control` in this order: start code 3'b111, slave ID, RW (1 = write),
// B (1 = burst), start address. Once the frame is accepted, words move over
// 1-bit serial lines to and from an internal RAM. Reads go out on rD and
// writes come in on wD. Each word is sent MSB first.
//
// Ports:
//   clk      in   clock
//   rstN     in   asynchronous active-low reset
//   control  in   serial configuration frame
//   wD       in   serial write data, qualified by valid
//   valid    in   write bit valid (valid=0 stalls the write shifter)
//   last     in   master end-of-burst request
//   rD       out  serial read data, driven only while reading
//   ready    out  1 in IDLE/READ/WRITE, 0 while configuring or loading
//   err      out  one-cycle pulse for an addressed frame whose address is out of range
module serial_mem_slave #(
  parameter int    ADDR_DEPTH    = 2048,
  parameter int    DATA_WIDTH    = 32,
  parameter int    SLAVES        = 3,
  parameter int    S_ID_WIDTH    = $clog2(SLAVES + 1),
  parameter int    SLAVE_ID      = 1,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic clk,
  input  logic rstN,
  input  logic control,
  input  logic wD,
  input  logic valid,
  input  logic last,
  output logic rD,
  output logic ready,
  output logic err
);

  localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH);
  localparam int F          = 5 + S_ID_WIDTH + ADDR_WIDTH;
  localparam int CW         = $clog2(F + 1);
  localparam int BW         = $clog2(DATA_WIDTH + 1);

  localparam logic [ADDR_WIDTH:0]   C_DEPTH     = (ADDR_WIDTH + 1)'(ADDR_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_LAST = ADDR_WIDTH'(ADDR_DEPTH - 1);
  localparam logic [S_ID_WIDTH-1:0] C_ID        = S_ID_WIDTH'(SLAVE_ID);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_DECODE, S_RLOAD, S_READ, S_WRITE
  } state_t;

  state_t                  r_state, w_state_next;
  logic [F-1:0]            r_cfg;
  logic [CW-1:0]           r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_burst;
  logic                    r_last;
  logic [BW-1:0]           r_bcnt;
  logic [DATA_WIDTH-1:0]   r_rd_buf;
  logic [DATA_WIDTH-1:0]   r_wr_buf;
  logic [DATA_WIDTH-1:0]   r_mem [ADDR_DEPTH];

  // Field views of the captured frame (MSB first, so the start code is on top).
  logic [2:0]            w_start;
  logic [S_ID_WIDTH-1:0] w_id;
  logic                  w_rw;
  logic                  w_burst;
  logic [ADDR_WIDTH-1:0] w_cfg_addr;
  logic                  w_hit;
  logic                  w_range_ok;
  logic                  w_bit_last;
  logic                  w_wr_done;
  logic                  w_wr_abort;
  logic                  w_stop;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  assign w_start     = r_cfg[F-1 -: 3];
  assign w_id        = r_cfg[F-4 -: S_ID_WIDTH];
  assign w_rw        = r_cfg[ADDR_WIDTH+1];
  assign w_burst     = r_cfg[ADDR_WIDTH];
  assign w_cfg_addr  = r_cfg[ADDR_WIDTH-1:0];
  assign w_hit       = (w_start == 3'b111) && (w_id == C_ID);
  assign w_range_ok  = {1'b0, w_cfg_addr} < C_DEPTH;
  assign w_bit_last  = (r_bcnt == BW'(DATA_WIDTH - 1));
  assign w_wr_done   = (r_state == S_WRITE) && valid && w_bit_last;
  // A last request before any bit of the current word has arrived ends the
  // burst without touching the RAM. Completing a word takes priority.
  assign w_wr_abort  = (r_state == S_WRITE) && last && (r_bcnt == '0) && !w_wr_done;
  // A last request in the final bit cycle counts as well as an earlier latched one.
  assign w_stop      = !r_burst || r_last || last;
  assign w_addr_next = (r_addr == C_ADDR_LAST) ? '0 : r_addr + 1'b1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    rD           = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (control) w_state_next = S_CONFIG;
      end
      S_CONFIG: begin
        if (r_cnt == CW'(F - 1)) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_hit) begin
          w_state_next = S_IDLE;
        end else if (!w_range_ok) begin
          err          = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = w_rw ? S_WRITE : S_RLOAD;
        end
      end
      S_RLOAD: begin
        w_state_next = S_READ;
      end
      S_READ: begin
        ready = 1'b1;
        rD    = r_rd_buf[DATA_WIDTH-1];
        if (w_bit_last) w_state_next = w_stop ? S_IDLE : S_RLOAD;
      end
      S_WRITE: begin
        ready = 1'b1;
        if (w_wr_done) begin
          if (w_stop) w_state_next = S_IDLE;
        end else if (w_wr_abort) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cfg    <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_burst  <= 1'b0;
      r_last   <= 1'b0;
      r_bcnt   <= '0;
      r_rd_buf <= '0;
      r_wr_buf <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (control) begin
            r_cfg <= F'(1);
            r_cnt <= CW'(1);
          end
        end
        S_CONFIG: begin
          r_cfg <= {r_cfg[F-2:0], control};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DECODE: begin
          if (w_hit && w_range_ok) begin
            r_addr  <= w_cfg_addr;
            r_burst <= w_burst;
            r_last  <= 1'b0;
            r_bcnt  <= '0;
          end
        end
        S_RLOAD: begin
          r_rd_buf <= r_mem[r_addr];
          r_bcnt   <= '0;
        end
        S_READ: begin
          r_rd_buf <= r_rd_buf << 1;
          if (last) r_last <= 1'b1;
          if (w_bit_last) begin
            r_bcnt <= '0;
            if (!w_stop) r_addr <= w_addr_next;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (last) r_last <= 1'b1;
          if (valid) begin
            r_wr_buf <= {r_wr_buf[DATA_WIDTH-2:0], wD};
            if (w_bit_last) begin
              r_bcnt <= '0;
              if (!w_stop) r_addr <= w_addr_next;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The RAM port has no reset, so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_done) r_mem[r_addr] <= {r_wr_buf[DATA_WIDTH-2:0], wD};
  end

endmodule

// File: tb/tb_serial_mem_slave.sv
module tb_serial_mem_slave;
  localparam int DW = 8;
  localparam int AD = 12;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic control = 1'b0;
  logic wD = 1'b0;
  logic valid = 1'b0;
  logic last = 1'b0;
  logic rD, ready, err;

  always #5 clk = ~clk;

  serial_mem_slave #(
    .ADDR_DEPTH(AD), .DATA_WIDTH(DW), .SLAVES(3), .SLAVE_ID(1), .MEM_INIT_FILE("")
  ) dut (
    .clk(clk), .rstN(rstN), .control(control), .wD(wD), .valid(valid),
    .last(last), .rD(rD), .ready(ready), .err(err)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model [AD];
  logic [7:0] wdat [16];

  typedef struct {
    bit         rw;
    logic [1:0] id;
    logic [3:0] addr;
    logic [7:0] data;
    bit         exp_err;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives one frame; returns at the negedge of the decode cycle.
  task automatic send_frame(input logic [2:0] st, input logic [1:0] id, input logic rw,
                            input logic b, input logic [3:0] a);
    logic [10:0] f;
    f = {st, id, rw, b, a};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      control = f[i];
    end
    @(negedge clk);
    control = 1'b0;
  endtask

  // One complete transaction. Every expectation comes from the model memory
  // and the addressing rules: only ID 1 answers, and addresses 0..11 are valid.
  task automatic xfer(input logic [1:0] id, input logic rw, input logic b, input logic [3:0] a,
                      input int nw_in, input bit stall,
                      output logic got_err, output logic [7:0] got_rd);
    logic acc, bad;
    int   ad, nw;
    logic [7:0] w;
    int   lp;
    got_rd = 8'h00;
    acc = (id == 2'd1);
    bad = acc && (a >= 4'd12);
    nw  = b ? nw_in : 1;
    valid = 1'b0;
    last  = 1'b0;
    send_frame(3'b111, id, rw, b, a);
    got_err = err;
    check("dec_ready", ready, 0);
    check("dec_err", err, bad);
    if (!acc || bad) begin
      @(negedge clk);
      check("rej_ready", ready, 1);
      check("rej_err", err, 0);
      return;
    end
    ad = int'(a);
    if (rw) begin
      for (int wi = 0; wi < nw; wi++) begin
        for (int bi = 7; bi >= 0; bi--) begin
          if (stall) begin
            repeat ($urandom_range(0, 2)) begin
              @(negedge clk);
              check("wr_stall_ready", ready, 1);
              valid = 1'b0;
              last  = 1'b0;
              wD    = 1'($urandom);
            end
          end
          @(negedge clk);
          check("wr_ready", ready, 1);
          valid = 1'b1;
          wD    = wdat[wi][bi];
          last  = b && (wi == nw - 1) && (bi == 0);
        end
        model[ad] = wdat[wi];
        ad = (ad == AD - 1) ? 0 : ad + 1;
      end
      @(negedge clk);
      valid = 1'b0;
      last  = 1'b0;
      check("wr_end_ready", ready, 1);
    end else begin
      @(negedge clk);
      check("rload_ready", ready, 0);
      check("rload_rd", rD, 0);
      for (int wi = 0; wi < nw; wi++) begin
        lp = $urandom_range(0, 7);
        for (int bi = 7; bi >= 0; bi--) begin
          @(negedge clk);
          check("rd_ready", ready, 1);
          w[bi] = rD;
          last  = b && (wi == nw - 1) && ((7 - bi) == lp);
        end
        check("rd_data", w, model[ad]);
        got_rd = w;
        @(negedge clk);
        last = 1'b0;
        if (wi < nw - 1) begin
          check("rd_gap_ready", ready, 0);
          check("rd_gap_rd", rD, 0);
          ad = (ad == AD - 1) ? 0 : ad + 1;
        end else begin
          check("rd_idle_ready", ready, 1);
          check("rd_idle_rd", rD, 0);
        end
      end
    end
  endtask

  initial begin
    logic       e;
    logic [7:0] r;
    logic [1:0] ids [6];

    tbl[0]  = '{1'b1, 2'd1, 4'd5,  8'hA5, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 4'd3,  8'h3C, 1'b0};
    tbl[2]  = '{1'b0, 2'd1, 4'd5,  8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 2'd1, 4'd3,  8'h3C, 1'b0};
    tbl[4]  = '{1'b1, 2'd2, 4'd5,  8'hFF, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 4'd5,  8'hA5, 1'b0};
    tbl[6]  = '{1'b1, 2'd1, 4'd13, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 2'd1, 4'd15, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 2'd3, 4'd3,  8'h77, 1'b0};
    tbl[9]  = '{1'b0, 2'd1, 4'd3,  8'h3C, 1'b0};
    tbl[10] = '{1'b1, 2'd1, 4'd11, 8'h80, 1'b0};
    tbl[11] = '{1'b0, 2'd1, 4'd11, 8'h80, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_rd", rD, 0);
    check("rst_err", err, 0);
    rstN = 1'b1;
    @(negedge clk);

    // Fill the whole RAM with one 12-word burst so every later read is defined.
    for (int i = 0; i < AD; i++) wdat[i] = 8'(i * 17 + 3);
    xfer(2'd1, 1'b1, 1'b1, 4'd0, AD, 1'b0, e, r);

    // Table of single-word transactions with constant expectations.
    for (int i = 0; i < 12; i++) begin
      wdat[0] = tbl[i].data;
      xfer(tbl[i].id, tbl[i].rw, 1'b0, tbl[i].addr, 1, 1'b0, e, r);
      check("tbl_err", e, tbl[i].exp_err);
      if (!tbl[i].rw && !tbl[i].exp_err) check("tbl_rd", r, tbl[i].data);
    end

    // Write burst that wraps from 11 to 0, with stalls and last on the final bit.
    wdat[0] = 8'h11;
    wdat[1] = 8'h22;
    xfer(2'd1, 1'b1, 1'b1, 4'd11, 2, 1'b1, e, r);
    xfer(2'd1, 1'b0, 1'b0, 4'd11, 1, 1'b0, e, r);
    check("wrap_rd11", r, 8'h11);
    xfer(2'd1, 1'b0, 1'b0, 4'd0, 1, 1'b0, e, r);
    check("wrap_rd0", r, 8'h22);
    xfer(2'd1, 1'b0, 1'b0, 4'd1, 1, 1'b0, e, r);
    check("wrap_rd1", r, 8'h14);

    // Three-word read burst with a one-cycle gap between words.
    wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h03;
    xfer(2'd1, 1'b1, 1'b1, 4'd6, 3, 1'b0, e, r);
    xfer(2'd1, 1'b0, 1'b1, 4'd6, 3, 1'b0, e, r);
    check("rdburst_last", r, 8'h03);

    // A last request with no bits of the word received ends the write with no RAM update.
    send_frame(3'b111, 2'd1, 1'b1, 1'b1, 4'd4);
    @(negedge clk);
    last = 1'b1;
    @(negedge clk);
    last = 1'b0;
    check("abort_ready", ready, 1);
    xfer(2'd1, 1'b0, 1'b0, 4'd4, 1, 1'b0, e, r);
    check("abort_rd4", r, 8'h47);

    // A frame with a bad start code is dropped without an error pulse.
    send_frame(3'b110, 2'd1, 1'b0, 1'b0, 4'd2);
    check("badstart_err", err, 0);
    @(negedge clk);
    check("badstart_ready", ready, 1);

    // Reset in the middle of a write: outputs go idle immediately and the partial word is discarded.
    send_frame(3'b111, 2'd1, 1'b1, 1'b0, 4'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = 1'b1;
      wD    = 1'b1;
    end
    @(negedge clk);
    rstN  = 1'b0;
    valid = 1'b0;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_rd", rD, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rstN = 1'b1;
    xfer(2'd1, 1'b0, 1'b0, 4'd2, 1, 1'b0, e, r);
    check("midrst_rd2", r, 8'h25);

    // Random transactions checked against the model memory.
    ids = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    for (int t = 0; t < 40; t++) begin
      logic [1:0] id;
      logic       rw, b;
      logic [3:0] a;
      int         nw;
      id = ids[$urandom_range(0, 5)];
      rw = 1'($urandom);
      b  = 1'($urandom);
      a  = 4'($urandom_range(0, 15));
      nw = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) wdat[k] = 8'($urandom);
      xfer(id, rw, b, a, nw, 1'($urandom), e, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
